// File: rtl/raw_frame_packer.sv
// Packs a stream of 16-bit raw samples into framed 32-bit words for the host read FIFO:
// header, sample pairs (last one zero-padded), and a trailer carrying the frame checksum.
module raw_frame_packer #(
  parameter int unsigned FRAME_LEN = 67,
  parameter logic [7:0]  SYNC_HDR  = 8'hA5,
  parameter logic [7:0]  SYNC_TRL  = 8'h5A
) (
  input  logic        iClk,
  input  logic        iReset,
  input  logic        iSampleValid,
  input  logic [15:0] i16Sample,
  input  logic [7:0]  i8SignSel,
  input  logic        iFifoFull,
  output logic        oFifoWrEn,
  output logic [31:0] o32FifoData,
  output logic        oBusy,
  output logic        oOverflow,
  output logic [15:0] o16FrameCnt
);

  localparam logic [7:0] LEN8 = 8'(FRAME_LEN);

  typedef enum logic [2:0] {IDLE, HEADER, PACK, FLUSH, TRAILER} state_t;
  state_t state, state_nxt;

  // Each entry carries the selector seen at write time, so the header reads it from the head entry.
  logic [23:0] mem [8];
  logic [2:0]  wr_ptr, rd_ptr;
  logic [3:0]  count;
  logic        full, empty, push, pop;
  logic [15:0] head_sample;
  logic [7:0]  head_sign;

  logic [7:0]  pop_cnt;
  logic [15:0] hi, sum, frame_cnt;
  logic        have_hi, word_valid, overflow;
  logic [31:0] word, data;
  logic        wr;

  assign full        = (count == 4'd8);
  assign empty       = (count == 4'd0);
  assign push        = iSampleValid && !full;
  assign head_sample = mem[rd_ptr][15:0];
  assign head_sign   = mem[rd_ptr][23:16];

  always_ff @(posedge iClk) begin
    if (push) mem[wr_ptr] <= {i8SignSel, i16Sample};
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      wr_ptr   <= 3'd0;
      rd_ptr   <= 3'd0;
      count    <= 4'd0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 3'd1;
      if (pop)  rd_ptr <= rd_ptr + 3'd1;
      count <= count + {3'b0, push} - {3'b0, pop};
      if (iSampleValid && full) overflow <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    wr        = 1'b0;
    pop       = 1'b0;
    data      = 32'h0;
    case (state)
      IDLE: begin
        if (!empty) state_nxt = HEADER;
      end
      HEADER: begin
        data = {SYNC_HDR, head_sign, frame_cnt};
        if (!iFifoFull) begin
          wr        = 1'b1;
          state_nxt = PACK;
        end
      end
      PACK: begin
        data = word;
        wr   = word_valid && !iFifoFull;
        // A held word that cannot leave blocks the next pairing.
        pop  = !empty && (pop_cnt != LEN8) && !(word_valid && iFifoFull);
        if ((pop_cnt == LEN8) && (!word_valid || wr))
          state_nxt = have_hi ? FLUSH : TRAILER;
      end
      FLUSH: begin
        data = {hi, 16'h0000};
        if (!iFifoFull) begin
          wr        = 1'b1;
          state_nxt = TRAILER;
        end
      end
      TRAILER: begin
        data = {SYNC_TRL, LEN8, sum};
        if (!iFifoFull) begin
          wr        = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state      <= IDLE;
      pop_cnt    <= 8'd0;
      hi         <= 16'h0;
      have_hi    <= 1'b0;
      word       <= 32'h0;
      word_valid <= 1'b0;
      sum        <= 16'h0;
      frame_cnt  <= 16'h0;
    end else begin
      state <= state_nxt;
      if (wr && state == PACK) word_valid <= 1'b0;
      if (pop) begin
        pop_cnt <= pop_cnt + 8'd1;
        sum     <= sum + head_sample;
        if (have_hi) begin
          word       <= {hi, head_sample};
          word_valid <= 1'b1;
          have_hi    <= 1'b0;
        end else begin
          hi      <= head_sample;
          have_hi <= 1'b1;
        end
      end
      if (wr && state == FLUSH) have_hi <= 1'b0;
      if (wr && state == TRAILER) begin
        frame_cnt <= frame_cnt + 16'd1;
        pop_cnt   <= 8'd0;
        sum       <= 16'h0;
      end
    end
  end

  assign oFifoWrEn   = wr;
  assign o32FifoData = wr ? data : 32'h0;
  assign oBusy       = (state != IDLE) || !empty;
  assign oOverflow   = overflow;
  assign o16FrameCnt = frame_cnt;

endmodule

// File: tb/tb_raw_frame_packer.sv
// Bench for raw_frame_packer: directed and randomized frames checked against a word-list model.
module tb_raw_frame_packer;
  logic        clk = 1'b0;
  logic        rst, valid, full;
  logic [15:0] sample;
  logic [7:0]  sign;
  logic        wr_en, busy, ovf;
  logic [31:0] data;
  logic [15:0] fcnt;
  logic        rst2, valid2, full2;
  logic [15:0] sample2;
  logic        wr2, busy2, ovf2;
  logic [31:0] data2;
  logic [15:0] fcnt2;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int full_wr = 0;
  logic [31:0] got[$], got2[$];
  int          got_cyc[$];

  raw_frame_packer u_dut (
    .iClk(clk), .iReset(rst), .iSampleValid(valid), .i16Sample(sample), .i8SignSel(sign),
    .iFifoFull(full), .oFifoWrEn(wr_en), .o32FifoData(data), .oBusy(busy),
    .oOverflow(ovf), .o16FrameCnt(fcnt));

  raw_frame_packer #(.FRAME_LEN(2)) u_dut2 (
    .iClk(clk), .iReset(rst2), .iSampleValid(valid2), .i16Sample(sample2), .i8SignSel(sign),
    .iFifoFull(full2), .oFifoWrEn(wr2), .o32FifoData(data2), .oBusy(busy2),
    .oOverflow(ovf2), .o16FrameCnt(fcnt2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      got.push_back(data);
      got_cyc.push_back(cyc);
      if (full !== 1'b0) full_wr++;
    end
    if (wr2 === 1'b1) got2.push_back(data2);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected word list of one frame, straight from the framing rules.
  function automatic void build(input logic [15:0] s[$], input logic [7:0] sg, input logic [15:0] fc,
                                input int len, output logic [31:0] w[$]);
    int sum;
    logic [15:0] lo;
    sum = 0;
    w.delete();
    w.push_back({8'hA5, sg, fc});
    for (int i = 0; i < len; i += 2) begin
      lo = (i + 1 < len) ? s[i+1] : 16'h0000;
      w.push_back({s[i], lo});
    end
    for (int i = 0; i < len; i++) sum = (sum + int'(s[i])) % 65536;
    w.push_back({8'h5A, 8'(len), 16'(sum)});
  endfunction

  task automatic do_reset();
    rst = 1'b1; valid = 1'b0; full = 1'b0;
    tick(); tick();
    rst = 1'b0;
    got.delete(); got_cyc.delete(); full_wr = 0;
  endtask

  task automatic feed(input logic [15:0] s[$], input int full_at, input int full_len);
    for (int i = 0; i < s.size(); i++) begin
      valid = 1'b1; sample = s[i];
      full = (i >= full_at && i < full_at + full_len);
      tick();
    end
    valid = 1'b0; full = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b1; sample = 16'h1234; full = 1'b0;
    tick(); tick();
    vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL reset_wren got %b want 0", wr_en); end
    vectors++; if (data !== 32'h0) begin miscompares++; $display("FAIL reset_data got %h want 0", data); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got %b want 0", ovf); end
    vectors++; if (fcnt !== 16'h0) begin miscompares++; $display("FAIL reset_fcnt got %h want 0", fcnt); end
    valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] s[$];
    logic [31:0] exp[$];
    int c0;
    do_reset();
    sign = 8'h03;
    for (int i = 1; i <= 67; i++) s.push_back(16'(i));
    build(s, 8'h03, 16'h0, 67, exp);
    c0 = cyc;
    feed(s, 1000, 0);
    for (int k = 0; k < 300 && got.size() < exp.size(); k++) tick();
    tick(); tick(); tick();
    vectors++; if (got.size() != exp.size()) begin miscompares++; $display("FAIL directed_count got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      vectors++; if (got[i] !== exp[i]) begin miscompares++; $display("FAIL directed_word[%0d] got %h want %h", i, got[i], exp[i]); end
    end
    vectors++; if (got_cyc.size() == 0 || got_cyc[0] - c0 != 2) begin miscompares++; $display("FAIL header_latency got %0d want 2", got_cyc.size() ? got_cyc[0] - c0 : -1); end
    vectors++; if (fcnt !== 16'd1) begin miscompares++; $display("FAIL directed_fcnt got %h want 1", fcnt); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL directed_busy got %b want 0", busy); end
  endtask

  task automatic test_stall();
    logic [15:0] s[$];
    logic [31:0] exp[$];
    do_reset();
    sign = 8'h03;
    for (int i = 1; i <= 67; i++) s.push_back(16'(i));
    build(s, 8'h03, 16'h0, 67, exp);
    feed(s, 12, 3);
    for (int k = 0; k < 300 && got.size() < exp.size(); k++) tick();
    tick(); tick(); tick();
    vectors++; if (got.size() != exp.size()) begin miscompares++; $display("FAIL stall_count got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      vectors++; if (got[i] !== exp[i]) begin miscompares++; $display("FAIL stall_word[%0d] got %h want %h", i, got[i], exp[i]); end
    end
    vectors++; if (full_wr != 0) begin miscompares++; $display("FAIL stall_write_while_full got %0d want 0", full_wr); end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL stall_ovf got %b want 0", ovf); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] s1[$], s2[$];
    logic [31:0] exp[$], e2[$];
    do_reset();
    for (int i = 0; i < 67; i++) s1.push_back(16'($urandom));
    for (int i = 0; i < 67; i++) s2.push_back(16'($urandom));
    build(s1, 8'h03, 16'h0, 67, exp);
    build(s2, 8'h07, 16'h1, 67, e2);
    foreach (e2[i]) exp.push_back(e2[i]);
    for (int i = 0; i < 134; i++) begin
      sign = (i < 67) ? 8'h03 : 8'h07;
      sample = (i < 67) ? s1[i] : s2[i-67];
      valid = 1'b1; tick();
      valid = 1'b0; tick();
    end
    for (int k = 0; k < 300 && got.size() < exp.size(); k++) tick();
    tick(); tick(); tick();
    vectors++; if (got.size() != exp.size()) begin miscompares++; $display("FAIL b2b_count got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      vectors++; if (got[i] !== exp[i]) begin miscompares++; $display("FAIL b2b_word[%0d] got %h want %h", i, got[i], exp[i]); end
    end
    vectors++; if (fcnt !== 16'd2) begin miscompares++; $display("FAIL b2b_fcnt got %h want 2", fcnt); end
  endtask

  task automatic test_mid_reset();
    got.delete();
    sign = 8'h05;
    for (int i = 0; i < 20; i++) begin valid = 1'b1; sample = 16'($urandom); tick(); end
    valid = 1'b0;
    rst = 1'b1;
    tick();
    got.delete();
    vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL midrst_wren got %b want 0", wr_en); end
    vectors++; if (data !== 32'h0) begin miscompares++; $display("FAIL midrst_data got %h want 0", data); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got %b want 0", busy); end
    vectors++; if (fcnt !== 16'h0) begin miscompares++; $display("FAIL midrst_fcnt got %h want 0", fcnt); end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    vectors++; if (got.size() != 0) begin miscompares++; $display("FAIL midrst_no_writes got %0d want 0", got.size()); end
    sign = 8'h09;
    valid = 1'b1; sample = 16'h0bad; tick();
    valid = 1'b0;
    for (int k = 0; k < 20 && got.size() < 1; k++) tick();
    vectors++; if (got.size() < 1 || got[0] !== 32'hA5090000) begin miscompares++; $display("FAIL midrst_header got %h want a5090000", got.size() ? got[0] : 32'hx); end
  endtask

  task automatic test_random();
    logic [15:0] s[$];
    logic [31:0] exp[$], ef[$];
    logic [7:0]  sg;
    do_reset();
    for (int f = 0; f < 2; f++) begin
      s.delete();
      sg = 8'($urandom);
      sign = sg;
      for (int i = 0; i < 67; i++) s.push_back(16'($urandom));
      build(s, sg, 16'(f), 67, ef);
      foreach (ef[i]) exp.push_back(ef[i]);
      for (int i = 0; i < 67; i++) begin
        while ($urandom_range(2) != 0) begin valid = 1'b0; full = ($urandom_range(3) == 0); tick(); end
        valid = 1'b1; sample = s[i]; full = ($urandom_range(3) == 0);
        tick();
      end
      valid = 1'b0;
    end
    full = 1'b0;
    for (int k = 0; k < 300 && got.size() < exp.size(); k++) tick();
    tick(); tick(); tick();
    vectors++; if (got.size() != exp.size()) begin miscompares++; $display("FAIL rand_count got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      vectors++; if (got[i] !== exp[i]) begin miscompares++; $display("FAIL rand_word[%0d] got %h want %h", i, got[i], exp[i]); end
    end
    vectors++; if (full_wr != 0) begin miscompares++; $display("FAIL rand_write_while_full got %0d want 0", full_wr); end
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL rand_ovf got %b want 0", ovf); end
  endtask

  task automatic test_overflow();
    logic [15:0] s[$];
    logic [31:0] exp[$];
    do_reset();
    sign = 8'h0c;
    full = 1'b1;
    for (int i = 0; i < 9; i++) begin
      s.push_back(16'($urandom));
      valid = 1'b1; sample = s[i]; tick();
    end
    valid = 1'b0;
    tick();
    vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_set got %b want 1", ovf); end
    vectors++; if (got.size() != 0) begin miscompares++; $display("FAIL ovf_no_writes got %0d want 0", got.size()); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL ovf_busy got %b want 1", busy); end
    full = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    exp.push_back({8'hA5, 8'h0c, 16'h0000});
    for (int i = 0; i < 8; i += 2) exp.push_back({s[i], s[i+1]});
    vectors++; if (got.size() != exp.size()) begin miscompares++; $display("FAIL ovf_count got %0d want %0d", got.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      vectors++; if (got[i] !== exp[i]) begin miscompares++; $display("FAIL ovf_word[%0d] got %h want %h", i, got[i], exp[i]); end
    end
    vectors++; if (ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky got %b want 1", ovf); end
    do_reset();
    vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_cleared got %b want 0", ovf); end
  endtask

  task automatic test_len2();
    logic [15:0] s[$];
    logic [31:0] exp[$];
    s.push_back(16'hFFFF); s.push_back(16'h0002);
    sign = 8'h11;
    build(s, 8'h11, 16'h0, 2, exp);
    rst2 = 1'b0;
    for (int i = 0; i < 2; i++) begin valid2 = 1'b1; sample2 = s[i]; tick(); end
    valid2 = 1'b0;
    for (int k = 0; k < 30 && got2.size() < exp.size(); k++) tick();
    tick(); tick();
    vectors++; if (got2.size() != exp.size()) begin miscompares++; $display("FAIL len2_count got %0d want %0d", got2.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < got2.size(); i++) begin
      vectors++; if (got2[i] !== exp[i]) begin miscompares++; $display("FAIL len2_word[%0d] got %h want %h", i, got2[i], exp[i]); end
    end
    vectors++; if (fcnt2 !== 16'd1) begin miscompares++; $display("FAIL len2_fcnt got %h want 1", fcnt2); end
  endtask

  initial begin
    rst = 1'b1; valid = 1'b0; full = 1'b0; sample = 16'h0; sign = 8'h0;
    rst2 = 1'b1; valid2 = 1'b0; full2 = 1'b0; sample2 = 16'h0;
    test_reset();
    test_directed();
    test_stall();
    test_back_to_back();
    test_mid_reset();
    test_random();
    test_overflow();
    test_len2();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
